// File: rtl/rect_dispatch.sv
// Command FIFO and enable/done sequencer in front of render_rect.
// Optional screen clipping at pop time is built when RECT_DISPATCH_CLIP_EN is defined.
module rect_dispatch #(
  parameter int DEPTH        = 4,
  parameter int GUARD_CYCLES = 2,
  parameter int GAP_CYCLES   = 1
) (
  input  logic       clk,
  input  logic       resetn,
  // Handshake: a command transfers on a posedge where cmd_valid and cmd_ready are both high;
  // cmd_ready depends only on registered occupancy, never on cmd_valid.
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [8:0] cmd_origin_x,
  input  logic [7:0] cmd_origin_y,
  input  logic [8:0] cmd_width,
  input  logic [7:0] cmd_height,
  input  logic [2:0] cmd_back_color,
  input  logic       cmd_border,
  input  logic [2:0] cmd_border_color,
  output logic       rect_enable,
  output logic [8:0] rect_origin_x,
  output logic [7:0] rect_origin_y,
  output logic [8:0] rect_width,
  output logic [7:0] rect_height,
  output logic [2:0] rect_back_color,
  output logic       rect_border,
  output logic [2:0] rect_border_color,
  input  logic       rect_done,
  output logic       busy,
  output logic [$clog2(DEPTH):0] queue_count,
  output logic       cmd_dropped,
  output logic [1:0] state_dbg
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam int PW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    DRAW = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t          state;
  logic [40:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [GW-1:0]   guard_cnt;
  logic [PW-1:0]   gap_cnt;
  logic            push;
  logic            pop;

  logic [40:0]     head;
  logic [8:0]      h_x;
  logic [7:0]      h_y;
  logic [8:0]      h_w;
  logic [7:0]      h_h;
  logic [2:0]      h_back;
  logic            h_border;
  logic [2:0]      h_bcol;
  logic [8:0]      c_w;
  logic [7:0]      c_h;
  logic            off_screen;
  logic            drop;

  assign cmd_ready   = (count != CW'(DEPTH));
  assign push        = cmd_valid && cmd_ready;
  assign pop         = (state == IDLE) && (count != '0);
  assign queue_count = count;
  assign busy        = (state != IDLE) || (count != '0);
  assign state_dbg   = state;

  // Storage has no reset: entries are only read behind a non-zero count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_origin_x, cmd_origin_y, cmd_width, cmd_height,
                              cmd_back_color, cmd_border, cmd_border_color};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    head = mem[rd_ptr];
    {h_x, h_y, h_w, h_h, h_back, h_border, h_bcol} = head;
    off_screen = 1'b0;
    c_w        = h_w;
    c_h        = h_h;
`ifdef RECT_DISPATCH_CLIP_EN
    off_screen = (h_x >= 9'd320) || (h_y >= 8'd240);
    if (h_w > (9'd320 - h_x)) c_w = 9'd320 - h_x;
    if (h_h > (8'd240 - h_y)) c_h = 8'd240 - h_y;
`endif
    // Zero-area test runs on the clipped size so a fully clipped rect is discarded too.
    drop = off_screen || (c_w == '0) || (c_h == '0);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state             <= IDLE;
      rect_enable       <= 1'b0;
      rect_origin_x     <= '0;
      rect_origin_y     <= '0;
      rect_width        <= '0;
      rect_height       <= '0;
      rect_back_color   <= '0;
      rect_border       <= 1'b0;
      rect_border_color <= '0;
      cmd_dropped       <= 1'b0;
      guard_cnt         <= '0;
      gap_cnt           <= '0;
    end else begin
      cmd_dropped <= 1'b0;
      case (state)
        IDLE: begin
          rect_enable <= 1'b0;
          if (pop) begin
            if (drop) begin
              cmd_dropped <= 1'b1;
            end else begin
              rect_origin_x     <= h_x;
              rect_origin_y     <= h_y;
              rect_width        <= c_w;
              rect_height       <= c_h;
              rect_back_color   <= h_back;
              rect_border       <= h_border;
              rect_border_color <= h_bcol;
              rect_enable       <= 1'b1;
              guard_cnt         <= '0;
              state             <= ARM;
            end
          end
        end
        // rect_done may still be high from the renderer's previous draw; ignore it here.
        ARM: begin
          if (guard_cnt == GW'(GUARD_CYCLES - 1)) state <= DRAW;
          else guard_cnt <= guard_cnt + GW'(1);
        end
        DRAW: begin
          if (rect_done) begin
            rect_enable <= 1'b0;
            gap_cnt     <= '0;
            state       <= GAP;
          end
        end
        GAP: begin
          if (gap_cnt == PW'(GAP_CYCLES - 1)) state <= IDLE;
          else gap_cnt <= gap_cnt + PW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rect_dispatch.sv
// Directed bench for rect_dispatch: draw sequencing, FIFO fill, done guard, drops, reset, clipping.
module tb_rect_dispatch;

  localparam int DEPTH = 4;
`ifdef RECT_DISPATCH_CLIP_EN
  localparam bit CLIP = 1'b1;
`else
  localparam bit CLIP = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic resetn = 1'b0;

  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [8:0] cmd_origin_x = '0;
  logic [7:0] cmd_origin_y = '0;
  logic [8:0] cmd_width = '0;
  logic [7:0] cmd_height = '0;
  logic [2:0] cmd_back_color = '0;
  logic       cmd_border = 1'b0;
  logic [2:0] cmd_border_color = '0;
  logic       rect_enable;
  logic [8:0] rect_origin_x;
  logic [7:0] rect_origin_y;
  logic [8:0] rect_width;
  logic [7:0] rect_height;
  logic [2:0] rect_back_color;
  logic       rect_border;
  logic [2:0] rect_border_color;
  logic       rect_done = 1'b0;
  logic       busy;
  logic [2:0] queue_count;
  logic       cmd_dropped;
  logic [1:0] state_dbg;

  rect_dispatch #(.DEPTH(DEPTH), .GUARD_CYCLES(2), .GAP_CYCLES(1)) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_origin_x(cmd_origin_x), .cmd_origin_y(cmd_origin_y),
    .cmd_width(cmd_width), .cmd_height(cmd_height),
    .cmd_back_color(cmd_back_color), .cmd_border(cmd_border),
    .cmd_border_color(cmd_border_color),
    .rect_enable(rect_enable),
    .rect_origin_x(rect_origin_x), .rect_origin_y(rect_origin_y),
    .rect_width(rect_width), .rect_height(rect_height),
    .rect_back_color(rect_back_color), .rect_border(rect_border),
    .rect_border_color(rect_border_color),
    .rect_done(rect_done), .busy(busy), .queue_count(queue_count),
    .cmd_dropped(cmd_dropped), .state_dbg(state_dbg)
  );

  // scoreboard counters
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic [8:0] x, input logic [7:0] y, input logic [8:0] w,
                           input logic [7:0] h, input logic [2:0] bc, input logic b,
                           input logic [2:0] bcol);
    cmd_origin_x     = x;
    cmd_origin_y     = y;
    cmd_width        = w;
    cmd_height       = h;
    cmd_back_color   = bc;
    cmd_border       = b;
    cmd_border_color = bcol;
    cmd_valid        = 1'b1;
  endtask

  task automatic finish_draw(input string tag);
    rect_done = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (!rect_enable) break;
      tick();
    end
    check(tag, rect_enable, 0);
    rect_done = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int hi;

    // reset state
    #1;
    check("rst_enable", rect_enable, 0);
    check("rst_count", queue_count, 0);
    check("rst_busy", busy, 0);
    check("rst_dropped", cmd_dropped, 0);
    check("rst_attr", {rect_origin_x, rect_width, rect_border_color}, 0);
    tick();
    tick();
    resetn = 1'b1;
    tick();
    check("rst_ready", cmd_ready, 1);

    // 1: single draw, attributes and enable timing
    drive_cmd(9'd10, 8'd20, 9'd4, 8'd3, 3'b010, 1'b1, 3'b111);
    tick();
    cmd_valid = 1'b0;
    check("t1_count_acc", queue_count, 1);
    check("t1_en_acc", rect_enable, 0);
    tick();
    check("t1_en_pop", rect_enable, 1);
    check("t1_x", rect_origin_x, 10);
    check("t1_y", rect_origin_y, 20);
    check("t1_w", rect_width, 4);
    check("t1_h", rect_height, 3);
    check("t1_back", rect_back_color, 3'b010);
    check("t1_border", rect_border, 1);
    check("t1_bcol", rect_border_color, 3'b111);
    check("t1_state_arm", state_dbg, 1);
    check("t1_count_pop", queue_count, 0);
    check("t1_busy", busy, 1);
    hi = 0;
    repeat (11) begin
      tick();
      if (rect_enable) hi++;
    end
    check("t1_en_hold", hi, 11);
    rect_done = 1'b1;
    tick();
    check("t1_en_drop", rect_enable, 0);
    rect_done = 1'b0;
    tick();
    tick();
    check("t1_busy_end", busy, 0);

    // 2: fill the FIFO during a draw, then drain two with latency checks
    for (int k = 0; k < 5; k++) begin
      drive_cmd(9'(100 + k), 8'(50 + k), 9'(8 + k), 8'd6, 3'(k), 1'(k), 3'(7 - k));
      check("t2_ready_fill", cmd_ready, 1);
      tick();
    end
    cmd_valid = 1'b0;
    check("t2_count_full", queue_count, 4);
    check("t2_ready_full", cmd_ready, 0);
    check("t2_en", rect_enable, 1);
    check("t2_x_first", rect_origin_x, 100);
    check("t2_w_first", rect_width, 8);
    repeat (3) tick();
    check("t2_x_hold", rect_origin_x, 100);
    check("t2_count_hold", queue_count, 4);
    check("t2_state_draw", state_dbg, 2);
    rect_done = 1'b1;
    tick();
    check("t2_en_low_m", rect_enable, 0);
    check("t2_count_m", queue_count, 4);
    rect_done = 1'b0;
    tick();
    check("t2_en_low_m1", rect_enable, 0);
    tick();
    tick();
    check("t2_en_high_m3", rect_enable, 1);
    check("t2_x_second", rect_origin_x, 101);
    check("t2_count_second", queue_count, 3);
    repeat (2) tick();
    rect_done = 1'b1;
    tick();
    rect_done = 1'b0;
    repeat (3) tick();
    check("t2_x_third", rect_origin_x, 102);
    check("t2_count_third", queue_count, 2);
    repeat (2) tick();
    check("t2_state_draw3", state_dbg, 2);

    // 5: reset mid-draw with two queued
    resetn = 1'b0;
    #1;
    check("t5_en_reset", rect_enable, 0);
    check("t5_count_reset", queue_count, 0);
    check("t5_busy_reset", busy, 0);
    check("t5_x_reset", rect_origin_x, 0);
    tick();
    resetn = 1'b1;
    hi = 0;
    repeat (5) begin
      tick();
      if (rect_enable) hi++;
    end
    check("t5_no_enable", hi, 0);
    check("t5_busy_after", busy, 0);
    check("t5_ready_after", cmd_ready, 1);

    // 3: done stuck high from before the draw
    rect_done = 1'b1;
    drive_cmd(9'd30, 8'd40, 9'd5, 8'd5, 3'b001, 1'b0, 3'b010);
    tick();
    cmd_valid = 1'b0;
    hi = 0;
    repeat (8) begin
      tick();
      if (rect_enable) hi++;
    end
    check("t3_enable_cycles", hi, 3);
    rect_done = 1'b0;
    tick();

    // 4: zero-width command discarded, next one draws
    drive_cmd(9'd50, 8'd50, 9'd0, 8'd5, 3'b001, 1'b1, 3'b001);
    tick();
    drive_cmd(9'd60, 8'd60, 9'd2, 8'd2, 3'b101, 1'b0, 3'b011);
    tick();
    cmd_valid = 1'b0;
    check("t4_dropped", cmd_dropped, 1);
    check("t4_en_drop", rect_enable, 0);
    check("t4_count", queue_count, 1);
    tick();
    check("t4_dropped_clear", cmd_dropped, 0);
    check("t4_en_second", rect_enable, 1);
    check("t4_x_second", rect_origin_x, 60);
    check("t4_w_second", rect_width, 2);
    finish_draw("t4_end");

    // 6: clipping (pass-through when the clip build is off)
    drive_cmd(9'd315, 8'd238, 9'd20, 8'd10, 3'b110, 1'b0, 3'b000);
    tick();
    cmd_valid = 1'b0;
    tick();
    check("t6_en", rect_enable, 1);
    check("t6_x", rect_origin_x, 315);
    check("t6_w", rect_width, CLIP ? 5 : 20);
    check("t6_h", rect_height, CLIP ? 2 : 10);
    finish_draw("t6_end");
    drive_cmd(9'd320, 8'd0, 9'd1, 8'd1, 3'b011, 1'b0, 3'b000);
    tick();
    cmd_valid = 1'b0;
    tick();
    check("t6_off_dropped", cmd_dropped, CLIP ? 1 : 0);
    check("t6_off_en", rect_enable, CLIP ? 0 : 1);
    finish_draw("t6_off_end");
    check("t6_idle_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
